// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ
// requesters, with an ACCESS-phase watchdog for stalled slaves.
module apb_rr_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_slverr,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic                             psel,
  output logic                             penable,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic                             pready,
  input  logic [DATA_WIDTH-1:0]            prdata,
  input  logic                             pslverr
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TMAX = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_gnt;
  logic [PW-1:0]         w_gnt;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmo;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]         r_cnt;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;

  // First valid lane at or above the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_gnt   = PW'(j);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !rst;
  assign w_done   = (r_state == S_ACCESS) && pready;
  assign w_tmo    = WD_EN && (r_state == S_ACCESS) && !pready
                    && (r_cnt >= TMAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next           = S_SETUP;
          req_ready[w_gnt] = 1'b1;
        end
      end
      S_SETUP: begin
        psel   = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (w_done || w_tmo) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_gnt   <= w_gnt;
        r_write <= req_write[w_gnt];
        r_addr  <= req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        r_cnt   <= '0;
        if (int'(w_gnt) == NUM_REQ - 1) r_ptr <= '0;
        else                            r_ptr <= w_gnt + 1'b1;
      end
      if (r_state == S_ACCESS && !pready && r_cnt != CMAX)
        r_cnt <= r_cnt + 1'b1;
      // pready beats the watchdog when both land in the same cycle
      if (w_done) begin
        r_rsp_valid[r_gnt] <= 1'b1;
        r_rsp_slverr       <= pslverr;
        r_rsp_rdata        <= r_write ? '0 : prdata;
      end else if (w_tmo) begin
        r_rsp_valid[r_gnt] <= 1'b1;
        r_rsp_slverr       <= 1'b1;
        r_rsp_rdata        <= '0;
      end
    end
  end

  assign paddr      = r_addr;
  assign pwrite     = r_write;
  assign pwdata     = r_wdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_slverr = r_rsp_slverr;

  // An accepted requester stays quiet until its response arrives.
  a_no_reassert: assert property (@(posedge clk) disable iff (rst)
    (r_state != S_IDLE) |-> !req_valid[r_gnt]);

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter: read, round-robin,
// wait states with error, watchdog, reset mid-transfer, terminal count.
module tb_apb_rr_master_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_slverr;
  logic [AW-1:0]  paddr;
  logic           pwrite;
  logic           psel;
  logic           penable;
  logic [DW-1:0]  pwdata;
  logic           pready;
  logic [DW-1:0]  prdata;
  logic           pslverr;

  int tests = 0;
  int fails = 0;

  apb_rr_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};
  logic [NR-1:0] vmask;
  logic [NR-1:0] onehot;

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    @(negedge clk) rst = 1'b0;

    // single read from lane 2
    @(negedge clk);
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 32'h40;
    #1 chk("rd_ready", req_ready, 4'b0100);
    chk("rd_idle_psel", psel, 0);
    @(negedge clk);
    chk("rd_setup_psel", psel, 1);
    chk("rd_setup_penable", penable, 0);
    chk("rd_setup_paddr", paddr, 32'h40);
    chk("rd_setup_pwrite", pwrite, 0);
    chk("rd_setup_ready", req_ready, 0);
    req_valid = '0; pready = 1'b1; prdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_access_penable", penable, 1);
    chk("rd_access_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 4'b0100);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_slverr", rsp_slverr, 0);
    chk("rd_done_psel", psel, 0);

    // round robin over lanes 0,1,3 starting from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    vmask = 4'b1011;
    req_valid = vmask;
    #1 chk("rr_rst_ready", req_ready, 0);
    chk("rr_rst_paddr", paddr, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      onehot = 4'b0001 << order[i];
      #1 chk("rr_grant", req_ready, 64'(onehot));
      @(negedge clk) req_valid = vmask & ~onehot;
      @(negedge clk);
      @(negedge clk);
      chk("rr_rsp", rsp_valid, 64'(onehot));
      req_valid = vmask;
    end
    req_valid = '0;
    pready = 1'b0;

    // write with five wait states and a slave error (pointer at 0)
    @(negedge clk);
    req_valid = 4'b0010;
    req_write[1] = 1'b1;
    req_addr[1*AW +: AW] = 32'h8;
    req_wdata[1*DW +: DW] = 32'h1234;
    prdata = 32'hFFFF_FFFF;
    #1 chk("ws_ready", req_ready, 4'b0010);
    @(negedge clk);
    chk("ws_setup_paddr", paddr, 32'h8);
    chk("ws_setup_pwdata", pwdata, 32'h1234);
    chk("ws_setup_pwrite", pwrite, 1);
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("ws_penable", penable, 1);
      chk("ws_paddr", paddr, 32'h8);
      chk("ws_pwdata", pwdata, 32'h1234);
      if (k == 5) begin
        pready = 1'b1; pslverr = 1'b1;
      end
    end
    @(negedge clk);
    chk("ws_rsp_valid", rsp_valid, 4'b0010);
    chk("ws_rsp_slverr", rsp_slverr, 1);
    chk("ws_rsp_rdata", rsp_rdata, 0);
    chk("ws_idle_psel", psel, 0);
    chk("ws_hold_paddr", paddr, 32'h8);
    pready = 1'b0; pslverr = 1'b0;

    // watchdog: lane 3 read, slave never ready (pointer at 2)
    @(negedge clk);
    req_valid = 4'b1000;
    req_write[3] = 1'b0;
    req_addr[3*AW +: AW] = 32'h100;
    #1 chk("to_ready", req_ready, 4'b1000);
    @(negedge clk) req_valid = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("to_access_penable", penable, 1);
      chk("to_access_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    chk("to_psel", psel, 0);
    chk("to_penable", penable, 0);
    chk("to_rsp_valid", rsp_valid, 4'b1000);
    chk("to_rsp_slverr", rsp_slverr, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    req_valid = 4'b0001;
    req_addr[0] = 1'b0;
    #1 chk("to_next_ready", req_ready, 4'b0001);

    // reset during ACCESS of the lane 0 transfer
    @(negedge clk) req_valid = '0;
    @(negedge clk);
    chk("mr_penable", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_psel", psel, 0);
    chk("mr_penable_low", penable, 0);
    chk("mr_rsp", rsp_valid, 0);
    req_valid = 4'b1001;
    req_addr[0*AW +: AW] = 32'h20;
    req_write[0] = 1'b0;
    #1 chk("mr_rst_ready", req_ready, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("mr_first_grant", req_ready, 4'b0001);
    chk("mr_no_rsp", rsp_valid, 0);

    // pready on the 16th ACCESS cycle wins over the watchdog
    @(negedge clk) req_valid = 4'b1000;
    chk("tc_setup_paddr", paddr, 32'h20);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("tc_access_penable", penable, 1);
      if (k == 16) begin
        pready = 1'b1; prdata = 32'h55;
      end
    end
    @(negedge clk);
    chk("tc_rsp_valid", rsp_valid, 4'b0001);
    chk("tc_rsp_rdata", rsp_rdata, 32'h55);
    chk("tc_rsp_slverr", rsp_slverr, 0);
    req_valid = '0;
    pready = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_psel", psel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
